ddr3_rden_gen: RTL and testbench
================================

DDR3_RDEN_GEN -- requirements
Module: ddr3_rden_gen

Interface
REQ-001 Parameter BANKID, default 2: I/O bank whose read-enable input this block drives; reported on bank_id.
REQ-002 Parameter MAX_RL, default 20: largest supported read latency, in clocks.
REQ-003 Parameter BURST_CYCLES, default 4: clocks of read data per command.
REQ-004 Parameter PRE, default 1: preamble clocks of inrden before the data window.
REQ-005 Parameter POST, default 1: postamble clocks of inrden after the data window.
REQ-006 clk  in  1  single clock; all logic is on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 rd_cmd  in  1  single-cycle pulse: a read command was issued to DRAM this cycle.
REQ-009 cfg_rl  in  5  read latency in clocks.
REQ-010 err_clr  in  1  clears err_tccd.
REQ-011 inrden  out  1  read-enable window, driven to the bank INRDENI input.
REQ-012 rd_valid  out  1  high during the clocks in which read data is present.
REQ-013 busy  out  1  at least one accepted command is still in flight.
REQ-014 err_tccd  out  1  sticky flag: a command was dropped for a spacing violation.
REQ-015 bank_id  out  3  constant value BANKID.

Function
REQ-016 Latched latency rl_q: loads cfg_rl only on cycles where busy=0 and rd_cmd=0; cfg_rl changes while busy or on the rd_cmd cycle take effect only after the block returns idle.
REQ-017 Latency clamp: rl_q values below PRE+1 are used as PRE+1; values above MAX_RL are used as MAX_RL.
REQ-018 Command acceptance: an accepted rd_cmd at cycle T drives rd_valid=1 on cycles T+RL+1 through T+RL+BURST_CYCLES.
REQ-019 Window timing: an accepted rd_cmd at cycle T drives inrden=1 on cycles T+RL+1-PRE through T+RL+BURST_CYCLES+POST.
REQ-020 Overlapping windows: inrden is the OR of all in-flight windows, so adjacent or overlapping windows produce one continuous high with no glitch.
REQ-021 Spacing rule: an rd_cmd arriving fewer than BURST_CYCLES clocks after the last accepted command is dropped.
REQ-022 Dropped command effects: the command produces no inrden or rd_valid activity, and err_tccd is set on the next cycle.
REQ-023 First command: the first rd_cmd after reset or idle is always accepted.
REQ-024 err_tccd: stays set until err_clr=1; if err_clr and a violation occur in the same cycle, set wins.
REQ-025 busy: high from the cycle after an accepted rd_cmd until the cycle after the last inrden high cycle of all in-flight commands.
REQ-026 Pipeline: a command-tracking shift structure holds MAX_RL+BURST_CYCLES+POST entries, so any number of legally spaced commands can be in flight at once.
REQ-027 Registered outputs: all outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-028 While rst_n=0: inrden=0, rd_valid=0, busy=0, err_tccd=0, all pipeline entries are cleared, and the spacing counter reads "no prior command".
REQ-029 Reset mid-operation: asserting rst_n during an active window forces all outputs low immediately (asynchronously).
REQ-030 After release: commands accepted before the reset produce no residual activity after rst_n deasserts.
REQ-031 rl_q reset and reload: rl_q resets to MAX_RL and reloads from cfg_rl on the first idle cycle after reset.

Verification (BURST_CYCLES=4, PRE=1, POST=1, cfg_rl=6; cycle numbers are relative)
REQ-032 Single command: rd_cmd at 10 -> inrden high 16..21; rd_valid high 17..20; busy high 11..22.
REQ-033 Back-to-back commands: rd_cmd at 10 and 14 -> inrden continuously high 16..25; rd_valid continuously high 17..24; err_tccd stays 0.
REQ-034 Spacing violation: rd_cmd at 10 and 12 -> the second command is dropped; err_tccd=1 from 13 and holds until an err_clr pulse at 30 clears it at 31; inrden high 16..21 only.
REQ-035 Gapped commands: rd_cmd at 10 and 16 -> inrden continuously high 16..27 (postamble of the first meets preamble of the second); rd_valid high 17..20 and 23..26.
REQ-036 Reset mid-burst: rd_cmd at 10, rst_n low at 18 and released at 20 -> all outputs 0 from 18 onward; inrden stays 0 through cycle 40.
REQ-037 Latency change while busy: cfg_rl changed 6->9 at 12 with rd_cmd at 10 -> first window per RL=6; a second rd_cmd at 30 -> inrden high 39..44.

Source files
------------

// File: rtl/ddr3_rden_gen.sv
// Read-enable window generator for one DDR3 I/O bank: tracks issued read commands and drives the
// bank INRDEN window and the matching read-data-valid strobe.
module ddr3_rden_gen #(
  parameter int unsigned BANKID       = 2,
  parameter int unsigned MAX_RL       = 20,
  parameter int unsigned BURST_CYCLES = 4,
  parameter int unsigned PRE          = 1,
  parameter int unsigned POST         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_cmd,
  input  logic [4:0] cfg_rl,
  input  logic       err_clr,
  output logic       inrden,
  output logic       rd_valid,
  output logic       busy,
  output logic       err_tccd,
  output logic [2:0] bank_id
);

  localparam int unsigned DEPTH = MAX_RL + BURST_CYCLES + POST;
  localparam int unsigned GW    = $clog2(BURST_CYCLES + 1);
  localparam int          BC    = int'(BURST_CYCLES);
  localparam int          PR    = int'(PRE);
  localparam int          PO    = int'(POST);
  localparam int          MR    = int'(MAX_RL);

  logic [4:0]       rl_q;
  logic [DEPTH-1:0] sr_q, sr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             accept, viol;
  logic             inrden_d, rd_valid_d, busy_d, err_d;
  int               rl, lim, age;

  // gap_q saturates at BURST_CYCLES, which doubles as "no prior command".
  assign accept = rd_cmd && (gap_q >= GW'(BURST_CYCLES));
  assign viol   = rd_cmd && !accept;
  assign err_d  = viol || (err_tccd && !err_clr);

  always_comb begin
    rl = int'(rl_q);
    if (rl < PR + 1) begin
      rl = PR + 1;
    end else if (rl > MR) begin
      rl = MR;
    end
    lim        = rl + BC + PO;
    inrden_d   = 1'b0;
    rd_valid_d = 1'b0;
    busy_d     = accept;
    age        = 0;
    // sr_q[k] marks a command issued k+1 cycles ago; age is its distance to the next cycle.
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (sr_q[k]) begin
        age = k + 2;
        if (age >= rl + 1 - PR && age <= rl + BC + PO) inrden_d = 1'b1;
        if (age >= rl + 1 && age <= rl + BC) rd_valid_d = 1'b1;
        if (k <= lim - 1) busy_d = 1'b1;
      end
    end
    // Entries past the window retire so a later, longer latency never revives them.
    sr_d[0] = accept;
    for (int k = 1; k < int'(DEPTH); k++) begin
      sr_d[k] = sr_q[k-1] && (k <= lim - 1);
    end
    if (accept) begin
      gap_d = GW'(1);
    end else if (gap_q < GW'(BURST_CYCLES)) begin
      gap_d = gap_q + GW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rl_q     <= 5'(MAX_RL);
      sr_q     <= '0;
      gap_q    <= GW'(BURST_CYCLES);
      inrden   <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      err_tccd <= 1'b0;
    end else begin
      if (!busy && !rd_cmd) rl_q <= cfg_rl;
      sr_q     <= sr_d;
      gap_q    <= gap_d;
      inrden   <= inrden_d;
      rd_valid <= rd_valid_d;
      busy     <= busy_d;
      err_tccd <= err_d;
    end
  end

  assign bank_id = 3'(BANKID);

endmodule

// File: tb/tb_ddr3_rden_gen.sv
// Directed bench for ddr3_rden_gen: each scenario drives commands on fixed relative cycles and
// checks every output against hand-computed high ranges on every cycle.
module tb_ddr3_rden_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_cmd = 1'b0;
  logic [4:0] cfg_rl = 5'd6;
  logic       err_clr = 1'b0;
  logic       inrden, rd_valid, busy, err_tccd;
  logic [2:0] bank_id;

  int tests = 0;
  int fails = 0;

  ddr3_rden_gen #(
    .BANKID(2), .MAX_RL(20), .BURST_CYCLES(4), .PRE(1), .POST(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_cmd(rd_cmd), .cfg_rl(cfg_rl), .err_clr(err_clr),
    .inrden(inrden), .rd_valid(rd_valid), .busy(busy), .err_tccd(err_tccd), .bank_id(bank_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [2:0] obs,
                     input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic inr(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Ranges with lo > hi are empty. rst_lo/rst_hi bound the cycles held in reset.
  task automatic scenario(
    input string name, input logic [4:0] cfg0, input int ncyc,
    input int c1, input int c2, input int clr_at, input int cfg_at, input logic [4:0] cfg_new,
    input int rst_lo, input int rst_hi,
    input int i1l, input int i1h, input int i2l, input int i2h,
    input int v1l, input int v1h, input int v2l, input int v2h,
    input int b1l, input int b1h, input int b2l, input int b2h,
    input int el, input int eh);
    rd_cmd  = 1'b0;
    err_clr = 1'b0;
    cfg_rl  = cfg0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({name, ".rst_in"}, -1, {2'b0, inrden}, 3'd0);
    chk({name, ".rst_busy"}, -1, {2'b0, busy}, 3'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      rd_cmd  = (c == c1) || (c == c2);
      err_clr = (c == clr_at);
      if (c == cfg_at) cfg_rl = cfg_new;
      rst_n   = !((c >= rst_lo) && (c < rst_hi));
      #1;
      chk({name, ".inrden"}, c, {2'b0, inrden}, {2'b0, inr(c, i1l, i1h) || inr(c, i2l, i2h)});
      chk({name, ".rd_valid"}, c, {2'b0, rd_valid}, {2'b0, inr(c, v1l, v1h) || inr(c, v2l, v2h)});
      chk({name, ".busy"}, c, {2'b0, busy}, {2'b0, inr(c, b1l, b1h) || inr(c, b2l, b2h)});
      chk({name, ".err"}, c, {2'b0, err_tccd}, {2'b0, inr(c, el, eh)});
    end
    rd_cmd  = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset.inrden", -1, {2'b0, inrden}, 3'd0);
    chk("reset.rd_valid", -1, {2'b0, rd_valid}, 3'd0);
    chk("reset.busy", -1, {2'b0, busy}, 3'd0);
    chk("reset.err", -1, {2'b0, err_tccd}, 3'd0);
    chk("bank_id", -1, bank_id, 3'd2);

    scenario("single", 5'd6, 30, 10, -1, -1, -1, 5'd0, 1000, 1000,
             16, 21, 0, -1, 17, 20, 0, -1, 11, 22, 0, -1, 0, -1);
    scenario("b2b", 5'd6, 32, 10, 14, -1, -1, 5'd0, 1000, 1000,
             16, 25, 0, -1, 17, 24, 0, -1, 11, 26, 0, -1, 0, -1);
    scenario("viol", 5'd6, 36, 10, 12, 30, -1, 5'd0, 1000, 1000,
             16, 21, 0, -1, 17, 20, 0, -1, 11, 22, 0, -1, 13, 30);
    scenario("gapped", 5'd6, 34, 10, 16, -1, -1, 5'd0, 1000, 1000,
             16, 27, 0, -1, 17, 20, 23, 26, 11, 28, 0, -1, 0, -1);
    scenario("midrst", 5'd6, 41, 10, -1, -1, -1, 5'd0, 18, 20,
             16, 17, 0, -1, 17, 17, 0, -1, 11, 17, 0, -1, 0, -1);
    scenario("rlchg", 5'd6, 50, 10, 30, -1, 12, 5'd9, 1000, 1000,
             16, 21, 39, 44, 17, 20, 40, 43, 11, 22, 31, 45, 0, -1);
    scenario("clamplo", 5'd0, 24, 10, -1, -1, -1, 5'd0, 1000, 1000,
             12, 17, 0, -1, 13, 16, 0, -1, 11, 18, 0, -1, 0, -1);
    scenario("clamphi", 5'd31, 42, 10, -1, -1, -1, 5'd0, 1000, 1000,
             30, 35, 0, -1, 31, 34, 0, -1, 11, 36, 0, -1, 0, -1);
    // Violation and clear in the same cycle: the set must win.
    scenario("setwins", 5'd6, 36, 10, 12, 12, -1, 5'd0, 1000, 1000,
             16, 21, 0, -1, 17, 20, 0, -1, 11, 22, 0, -1, 13, 35);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
